// File: rtl/merge_noc_pkg.sv
// Shared types for the merge10 leaf arbiter: flit type, FSM states, tail helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package merge_noc_pkg;

  localparam int FLIT_W   = 9;
  localparam int TAIL_BIT = FLIT_W - 1;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // The top bit of every flit marks the last flit of a packet.
  function automatic logic is_tail(input flit_t f);
    return f[TAIL_BIT];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: one-hot grant, the requester that did not win last time wins a tie.
// Latency: purely combinational.
// Backpressure: none; the caller masks req when the grant cannot be used.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a tie the index opposite last_grant wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/merge10_leaf_arbiter.sv
// Packet-atomic round-robin 2:1 merge onto one leaf channel, with a source-ID token per packet.
// Latency: 1 cycle from input transfer to out_valid; header granted in the cycle it is eligible.
// Backpressure: inputs stall when the output register is full and not draining; headers also wait for a free S slot.
module merge10_leaf_arbiter
  import merge_noc_pkg::*;
#(
  parameter int W         = 9,
  parameter int MAX_FLITS = 16
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         err_overlen
);

  localparam int CW = $clog2(MAX_FLITS + 1);

  arb_state_t    state;
  logic          last_grant;
  logic [CW-1:0] cnt;

  logic          out_slot_free;
  logic          s_free;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          take0;
  logic          take1;
  logic          load;
  logic          hdr;
  logic [W-1:0]  sel_data;
  logic          tail;
  logic          at_limit;

  assign out_slot_free = !out_valid || out_ready;
  assign s_free        = !s_valid || s_ready;

  // A header may only start when both the flit slot and the token slot can take it.
  assign req = {in1_valid, in0_valid} & {2{out_slot_free && s_free}};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Ready generation: arbiter pick in IDLE, owner-only ready while a packet is open.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (_RESET) begin
      case (state)
        IDLE: begin
          in0_ready = gnt[0];
          in1_ready = gnt[1];
        end
        GRANT0:  in0_ready = out_slot_free;
        GRANT1:  in1_ready = out_slot_free;
        default: ;
      endcase
    end
  end

  assign take0    = in0_valid && in0_ready;
  assign take1    = in1_valid && in1_ready;
  assign load     = take0 || take1;
  assign hdr      = load && (state == IDLE);
  assign sel_data = take1 ? in1_data : in0_data;
  assign tail     = is_tail(flit_t'(sel_data));
  assign at_limit = (cnt == CW'(MAX_FLITS - 1));

  // Packet FSM, round-robin history and per-packet flit count.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else if (load) begin
      if (hdr) begin
        last_grant <= take1;
        cnt        <= CW'(1);
        if (tail) state <= IDLE;
        else      state <= take1 ? GRANT1 : GRANT0;
      end else begin
        cnt <= cnt + CW'(1);
        // Tail closes the packet; the MAX_FLITS-th non-tail flit force-closes it.
        if (tail || at_limit) state <= IDLE;
      end
    end
  end

  // Sticky truncation flag: only reset clears it.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET)                                err_overlen <= 1'b0;
    else if (load && !hdr && !tail && at_limit) err_overlen <= 1'b1;
  end

  // One-entry output register: fill on any transfer, empty when drained and not refilled.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Source-ID token: written by each header, cleared when consumed and not replaced.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      s_data  <= 1'b0;
      s_valid <= 1'b0;
    end else if (hdr) begin
      s_data  <= take1;
      s_valid <= 1'b1;
    end else if (s_ready) begin
      s_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_merge10_leaf_arbiter.sv
// Bench for merge10_leaf_arbiter: directed scenarios then randomized packets against a packet-level model.
// Latency: checks the 1-cycle input-to-output delay and zero-bubble packet gaps.
// Backpressure: exercises out_ready and s_ready stalls with hold-stability checks.
module tb_merge10_leaf_arbiter;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [8:0] in0_data, in1_data, out_data;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic       out_valid, out_ready;
  logic       s_data, s_valid, s_ready, err_overlen;

  always #5 CLK = ~CLK;

  merge10_leaf_arbiter #(.W(9), .MAX_FLITS(16)) dut (
    .CLK(CLK), ._RESET(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .err_overlen(err_overlen)
  );

  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  logic [8:0] src0[$], src1[$], got_out[$], exp_out[$], exp0[$], exp1[$];
  int         got_cyc[$];
  logic       got_s[$], got_err[$], exp_s[$];
  bit         rnd = 0, or_set = 1, sr_set = 1;
  bit         a0 = 0, a1 = 0, o_hold = 0, s_hold = 0;
  logic [8:0] o_prev;
  logic       s_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Producers present queue heads; a valid that was not taken is held with its data.
  task automatic drive();
    if (!(in0_valid && !a0)) in0_valid = (src0.size() > 0) && (!rnd || $urandom_range(3) != 0);
    if (!(in1_valid && !a1)) in1_valid = (src1.size() > 0) && (!rnd || $urandom_range(3) != 0);
    in0_data  = (src0.size() > 0) ? src0[0] : 9'h000;
    in1_data  = (src1.size() > 0) ? src1[0] : 9'h000;
    out_ready = rnd ? ($urandom_range(3) != 0) : or_set;
    s_ready   = rnd ? ($urandom_range(3) != 0) : sr_set;
  endtask

  // Sample at the falling edge, advance past the rising edge, then drive the next cycle.
  task automatic tick();
    @(negedge CLK);
    if (o_hold) begin
      chk("out_hold_valid", out_valid, 1);
      chk("out_hold_data", out_data, o_prev);
    end
    if (s_hold) begin
      chk("s_hold_valid", s_valid, 1);
      chk("s_hold_data", s_data, s_prev);
    end
    chk("ready_exclusive", in0_ready & in1_ready, 0);
    o_hold = out_valid && !out_ready; o_prev = out_data;
    s_hold = s_valid && !s_ready;     s_prev = s_data;
    if (out_valid && out_ready) begin
      got_out.push_back(out_data); got_cyc.push_back(cyc); got_err.push_back(err_overlen);
    end
    if (s_valid && s_ready) got_s.push_back(s_data);
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    @(posedge CLK); #1; cyc++;
    if (a0 && src0.size() > 0) src0.delete(0);
    if (a1 && src1.size() > 0) src1.delete(0);
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear();
    got_out.delete(); got_cyc.delete(); got_s.delete(); got_err.delete();
  endtask

  task automatic quiesce();
    src0.delete(); src1.delete();
    in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0;
    a0 = 0; a1 = 0; o_hold = 0; s_hold = 0;
  endtask

  task automatic do_reset();
    quiesce();
    rst_n = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); rst_n = 1;
    @(posedge CLK); #1; cyc++;
    or_set = 1; sr_set = 1; out_ready = 1; s_ready = 1;
    clear();
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_len"}, got_out.size(), exp_out.size());
    foreach (exp_out[i])
      chk($sformatf("%s_flit%0d", tag, i), (i < got_out.size()) ? got_out[i] : 9'h000, exp_out[i]);
    chk({tag, "_ntok"}, got_s.size(), exp_s.size());
    foreach (exp_s[i])
      chk($sformatf("%s_tok%0d", tag, i), (i < got_s.size()) ? got_s[i] : ~exp_s[i], exp_s[i]);
  endtask

  task automatic cmp_gap(input string tag);
    for (int i = 1; i < got_cyc.size(); i++)
      chk($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 1);
  endtask

  initial begin
    int         t0, guard, oi, len;
    bit         done;
    logic       src;
    logic [8:0] e, fl;

    rst_n = 0; in0_valid = 1; in1_valid = 1; in0_data = 9'h0AA; in1_data = 9'h0BB;
    out_ready = 1; s_ready = 1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_err", err_overlen, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    do_reset();

    // Single-flit packets from in0, one-cycle latency, back to back.
    src0 = '{9'h100, 9'h101};
    t0 = cyc; drive(); run(6);
    exp_out = '{9'h100, 9'h101}; exp_s = '{1'b0, 1'b0};
    cmp("single");
    chk("single_lat0", got_cyc[0], t0 + 1);
    chk("single_lat1", got_cyc[1], t0 + 2);

    // Contention after reset: in0 first, then strict alternation, whole packets, no bubbles.
    do_reset();
    src0 = '{9'h0A1, 9'h0A2, 9'h1A3, 9'h0A1, 9'h0A2, 9'h1A3};
    src1 = '{9'h0B1, 9'h0B2, 9'h1B3, 9'h0B1, 9'h0B2, 9'h1B3};
    drive(); run(16);
    exp_out = '{9'h0A1, 9'h0A2, 9'h1A3, 9'h0B1, 9'h0B2, 9'h1B3,
                9'h0A1, 9'h0A2, 9'h1A3, 9'h0B1, 9'h0B2, 9'h1B3};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    cmp("contend");
    cmp_gap("contend");

    // Output backpressure mid-packet: grant held, other input locked out, nothing lost.
    clear();
    src0 = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
    src1 = '{9'h1D1};
    drive(); run(2);
    or_set = 0; out_ready = 0;
    repeat (5) begin
      #1;
      chk("bp_in1_ready", in1_ready, 0);
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_out_data", out_data, 9'h0C2);
      tick();
    end
    or_set = 1; out_ready = 1;
    run(8);
    exp_out = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4, 9'h1D1}; exp_s = '{1'b0, 1'b1};
    cmp("bp");

    // S stall: pending token blocks the next header until s_ready rises.
    clear();
    sr_set = 0; s_ready = 0;
    src0 = '{9'h1E1}; src1 = '{9'h1F1};
    drive(); run(1);
    repeat (3) begin
      #1;
      chk("sstall_in1_ready", in1_ready, 0);
      chk("sstall_in0_ready", in0_ready, 0);
      chk("sstall_s_valid", s_valid, 1);
      chk("sstall_s_data", s_data, 0);
      tick();
    end
    sr_set = 1; s_ready = 1;
    #1 chk("sstall_release_grant", in1_ready, 1);
    run(5);
    exp_out = '{9'h1E1, 9'h1F1}; exp_s = '{1'b0, 1'b1};
    cmp("sstall");

    // Over-length: 17 non-tail flits on in1; truncated after 16, 17th opens a new packet.
    clear();
    chk("ovl_err_before", err_overlen, 0);
    for (int i = 1; i <= 17; i++) src1.push_back(9'(i));
    src1.push_back(9'h1FF);
    exp_out = src1; exp_s = '{1'b1, 1'b1};
    drive(); run(24);
    cmp("ovl");
    cmp_gap("ovl");
    chk("ovl_err_flit15", got_err[14], 0);
    chk("ovl_err_flit16", got_err[15], 1);
    chk("ovl_err_sticky", err_overlen, 1);

    // Reset in the middle of a 4-flit packet, token still pending.
    clear();
    sr_set = 0; s_ready = 0;
    src0 = '{9'h051, 9'h052, 9'h053, 9'h154};
    drive(); run(2);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_err", err_overlen, 0);
    chk("mid_rst_in0_ready", in0_ready, 0);
    chk("mid_rst_in1_ready", in1_ready, 0);
    quiesce();
    sr_set = 1; s_ready = 1;
    @(negedge CLK); rst_n = 1;
    @(posedge CLK); #1; cyc++;
    clear();
    src0 = '{9'h1A0}; src1 = '{9'h1B0};
    drive(); run(5);
    exp_out = '{9'h1A0, 9'h1B0}; exp_s = '{1'b0, 1'b1};
    cmp("post_rst");

    // Randomized packets: output must be whole packets, in per-source order, each tagged by S.
    clear(); exp0.delete(); exp1.delete();
    for (int p = 0; p < 24; p++) begin
      len = $urandom_range(1, 6);
      for (int f = 0; f < len; f++) begin
        fl = {(f == len - 1), 8'($urandom)};
        if (p % 2 == 0) begin src0.push_back(fl); exp0.push_back(fl); end
        else            begin src1.push_back(fl); exp1.push_back(fl); end
      end
    end
    rnd = 1; drive();
    guard = 0;
    while ((src0.size() > 0 || src1.size() > 0) && guard < 4000) begin
      tick(); guard++;
    end
    rnd = 0; or_set = 1; sr_set = 1;
    run(4);
    chk("rnd_finished_in_budget", guard < 4000, 1);
    oi = 0;
    foreach (got_s[k]) begin
      done = 0;
      src  = got_s[k];
      while (!done && oi < got_out.size()) begin
        if (src) e = (exp1.size() > 0) ? exp1.pop_front() : ~got_out[oi];
        else     e = (exp0.size() > 0) ? exp0.pop_front() : ~got_out[oi];
        chk($sformatf("rnd_pkt%0d_src%0d", k, src), got_out[oi], e);
        done = got_out[oi][8];
        oi++;
      end
    end
    chk("rnd_all_flits_owned", oi, got_out.size());
    chk("rnd_left0", exp0.size(), 0);
    chk("rnd_left1", exp1.size(), 0);
    chk("rnd_tokens", got_s.size(), 24);
    chk("rnd_err", err_overlen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/merge10_leaf_arbiter.md
Name: merge10_leaf_arbiter

Overview:
- Synchronous 2:1 packet merge. Companion to the decoder10 leaf: it shares one 9-bit leaf output channel between two requesters.
- Arbitration is round-robin and packet-atomic. The arbiter holds the grant from the header flit through the tail flit.
- For every packet it issues a 1-bit source-ID token on a side channel S, so downstream logic can route the response back.
- Sits between two leaf-side producers and the shared uplink buffer.

Parameters:
- W, 9, flit width. Bit W-1 is the tail marker; bits W-2:0 are payload.
- MAX_FLITS, 16, maximum flits per packet, header and tail included. Range 2..256.
- CW, $clog2(MAX_FLITS+1), width of the flit counter (derived localparam).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- in0_data  in  W  flit from requester 0.
- in0_valid  in  1  flit present on requester 0.
- in0_ready  out  1  arbiter accepts the in0 flit this cycle.
- in1_data, in1_valid, in1_ready  same as requester 0, for requester 1.
- out_data  out  W  registered merged flit.
- out_valid  out  1  out_data holds a flit.
- out_ready  in  1  downstream accepts the flit.
- s_data  out  1  source ID of the most recently started packet.
- s_valid  out  1  S token pending.
- s_ready  in  1  downstream consumes the S token.
- err_overlen  out  1  sticky flag: a packet exceeded MAX_FLITS and was truncated.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), cnt=0.
  - out_valid=0, out_data=0, s_valid=0, s_data=0, err_overlen=0.
  - in0_ready and in1_ready are 0 while _RESET is low.
  - Reset mid-packet abandons the packet; no tail is synthesised.
- Handshakes:
  - A transfer occurs when valid && ready are both high at the clock edge.
  - valid must not depend on ready.
  - Data must hold stable while valid is high and ready is low. The bench checks this on out_* and s_*.
- Output stage:
  - One-entry pipeline register; latency is 1 cycle from input transfer to out_valid.
  - out_slot_free = !out_valid || out_ready. A simultaneous drain and fill sustains 1 flit/cycle.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE, header transfer:
    - Eligible inputs are inK_valid=1, provided out_slot_free=1 and S is free (!s_valid || s_ready).
    - One eligible input: grant it. Both eligible: grant the input != last_grant.
    - The header transfers in the same cycle (no arbitration bubble): inK_ready=1, out register loads, s_data<=K, s_valid<=1, last_grant<=K, cnt<=1.
    - Header tail bit set (single-flit packet): stay IDLE. Otherwise go to GRANTK.
  - IDLE, stall: if S is not free or the out slot is not free, both readies are 0 and no grant is made.
  - GRANTK:
    - inK_ready=out_slot_free; the other ready is 0.
    - Each transfer: cnt<=cnt+1.
    - Tail transfer: go to IDLE.
    - A non-tail transfer with cnt==MAX_FLITS-1 (i.e. the MAX_FLITS-th flit) goes to IDLE and sets err_overlen<=1 (truncate).
    - Later flits from that requester are treated as a new header.
- S token: s_valid clears on s_ready unless a new header loads in the same cycle. A new header is only granted when S is free, so no token is ever lost.
- err_overlen clears only on reset.
- Simultaneous events: a header grant and an out drain in the same cycle is legal. Tail-to-IDLE and a new header in the next cycle give a minimum 0-bubble packet gap when the other requester is waiting.

Decomposition:
- Package merge_noc_pkg:
  - FLIT_W=9, TAIL_BIT=FLIT_W-1.
  - typedef logic [FLIT_W-1:0] flit_t.
  - typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t.
  - function is_tail(flit_t).
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req[1:0], last_grant) giving a one-hot grant. The FSM, flit counter and output/S registers stay in the top level.

Test Plan:
- Single-flit packets: in0 only sends 0x100, 0x101 with out_ready=1 -> out_data 0x100, 0x101 on consecutive cycles, 1-cycle latency; S tokens 0, 0.
- Contention: both inputs present 3-flit packets (0x0A1, 0x0A2, 0x1A3 on in0; 0x0B1, 0x0B2, 0x1B3 on in1) on the same cycle after reset -> in0's packet emitted whole, then in1's, with no interleave and no bubble; S tokens 0 then 1. Repeat -> in0 first again (round-robin alternation).
- Backpressure: hold out_ready=0 for 5 cycles mid-packet -> out_data stable, grant held, the other input's ready=0 throughout; resumes without flit loss.
- S stall: s_ready=0 after the first packet -> no second header granted, both in_ready=0 in IDLE. Raise s_ready -> the next header is granted that cycle.
- Over-length: in1 sends 17 flits with no tail, MAX_FLITS=16 -> 16 flits forwarded, err_overlen=1 after the 16th; the 17th flit starts a new packet with S token 1.
- Reset mid-packet: assert _RESET after flit 2 of 4 -> out_valid, s_valid, err_overlen and in_ready all 0 immediately. After release the state is IDLE and requester 0 wins the first tie.
